// File: rtl/bsg_dlatch_drain.sv
// Reader end for latch-captured words: registers a word, waits a fixed settle
// interval, then offers it downstream on a valid/yumi handshake.
module bsg_dlatch_drain #(
  parameter int unsigned width_p         = 16,
  parameter int unsigned settle_cycles_p = 2,
  parameter int unsigned count_width_p   = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [width_p-1:0]       data_i,
  input  logic                     v_i,
  output logic                     ready_o,
  output logic [width_p-1:0]       data_o,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic                     busy_o,
  output logic [count_width_p-1:0] drained_o
);

  localparam int unsigned CntW = (settle_cycles_p > 0) ? $clog2(settle_cycles_p + 1) : 1;
  localparam logic [CntW-1:0] SettleLoad = CntW'(settle_cycles_p);

  typedef enum logic [1:0] {StIdle, StSettle, StValid} state_e;

  state_e                   state_q, state_d, load_state;
  logic [CntW-1:0]          cnt_q;
  logic [width_p-1:0]       data_q;
  logic [count_width_p-1:0] drained_q;
  logic                     v_q, busy_q;
  logic                     accept, yumi_ok;

  // Same-cycle pass-through: a consumed word frees the slot for a new one.
  assign yumi_ok    = (state_q == StValid) & yumi_i;
  assign ready_o    = (state_q == StIdle) | yumi_ok;
  assign accept     = v_i & ready_o;
  assign load_state = (settle_cycles_p == 0) ? StValid : StSettle;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = load_state;
      StSettle: if (cnt_q <= CntW'(1)) state_d = StValid;
      StValid:  if (yumi_i) state_d = accept ? load_state : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      data_q    <= '0;
      drained_q <= '0;
      v_q       <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= (state_d == StValid);
      busy_q  <= (state_d != StIdle);
      if (accept) begin
        data_q <= data_i;
        cnt_q  <= SettleLoad;
      end else if (state_q == StSettle) begin
        cnt_q <= cnt_q - CntW'(1);
      end
      if (yumi_ok) drained_q <= drained_q + count_width_p'(1);
    end
  end

  assign data_o    = data_q;
  assign v_o       = v_q;
  assign busy_o    = busy_q;
  assign drained_o = drained_q;

`ifndef SYNTHESIS
  yumi_without_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("yumi_i asserted while v_o=0");
`endif

endmodule

// File: tb/tb_bsg_dlatch_drain.sv
// Scoreboard bench: dut A (settle 2, 8-bit count) and dut B (settle 0, 2-bit count).
module tb_bsg_dlatch_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_v_i, a_yumi_i, a_ready_o, a_v_o, a_busy_o;
  logic [15:0] a_data_i, a_data_o;
  logic [7:0]  a_drained_o;
  logic        b_rst_n, b_v_i, b_yumi_i, b_ready_o, b_v_o, b_busy_o;
  logic [15:0] b_data_i, b_data_o;
  logic [1:0]  b_drained_o;

  bsg_dlatch_drain #(.width_p(16), .settle_cycles_p(2), .count_width_p(8)) u_dut_a (
    .clk_i(clk), .reset_n_i(a_rst_n), .data_i(a_data_i), .v_i(a_v_i), .ready_o(a_ready_o),
    .data_o(a_data_o), .v_o(a_v_o), .yumi_i(a_yumi_i), .busy_o(a_busy_o),
    .drained_o(a_drained_o)
  );

  bsg_dlatch_drain #(.width_p(16), .settle_cycles_p(0), .count_width_p(2)) u_dut_b (
    .clk_i(clk), .reset_n_i(b_rst_n), .data_i(b_data_i), .v_i(b_v_i), .ready_o(b_ready_o),
    .data_o(b_data_o), .v_o(b_v_o), .yumi_i(b_yumi_i), .busy_o(b_busy_o),
    .drained_o(b_drained_o)
  );

  int          checks = 0;
  int          errors = 0;
  int          drn_a  = 0;
  int          drn_b  = 0;
  logic        sel_b  = 1'b0;
  logic [15:0] sb_q[$];
  logic [15:0] src_q[$];

  logic        cur_v_o, cur_ready_o, cur_busy_o;
  logic [15:0] cur_data_o;
  logic [31:0] cur_drained;
  assign cur_v_o     = sel_b ? b_v_o : a_v_o;
  assign cur_ready_o = sel_b ? b_ready_o : a_ready_o;
  assign cur_busy_o  = sel_b ? b_busy_o : a_busy_o;
  assign cur_data_o  = sel_b ? b_data_o : a_data_o;
  assign cur_drained = sel_b ? 32'(b_drained_o) : 32'(a_drained_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic y);
    if (sel_b) begin
      b_v_i = v; b_data_i = d; b_yumi_i = y;
    end else begin
      a_v_i = v; a_data_i = d; a_yumi_i = y;
    end
  endtask

  function automatic logic [31:0] exp_drained();
    return sel_b ? 32'(drn_b & 3) : 32'(drn_a & 255);
  endfunction

  // Pops the scoreboard against data_o and bumps the modelled drain count.
  task automatic consume(input string tag);
    logic [31:0] exp;
    exp = (sb_q.size() > 0) ? 32'(sb_q.pop_front()) : 'x;
    check(tag, 32'(cur_data_o), exp);
    if (sel_b) drn_b++;
    else drn_a++;
  endtask

  task automatic stream(input int period);
    int n, sent, got, last;
    n = src_q.size(); sent = 0; got = 0; last = -1;
    for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
      @(negedge clk);
      if (cur_v_o) begin
        consume("stream_data");
        if (last >= 0) check("stream_period", cyc - last, period);
        last = cyc;
        got++;
      end
      drive(sent < n, (sent < n) ? src_q[sent] : 16'h0, cur_v_o);
      #1;
      if (sent < n && cur_ready_o) begin
        sb_q.push_back(src_q[sent]);
        sent++;
      end
    end
    check("stream_count", got, n);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0);
    check("stream_drained", cur_drained, exp_drained());
    check("stream_idle_v", 32'(cur_v_o), 0);
  endtask

  initial begin
    int w;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_v_i = 0; a_yumi_i = 0; a_data_i = 0;
    b_v_i = 0; b_yumi_i = 0; b_data_i = 0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_v_i = 1'($urandom); a_yumi_i = 1'($urandom); a_data_i = 16'($urandom);
      b_v_i = 1'($urandom); b_yumi_i = 1'($urandom); b_data_i = 16'($urandom);
      #1;
      check("rst_v", 32'(a_v_o), 0);
      check("rst_data", 32'(a_data_o), 0);
      check("rst_drained", 32'(a_drained_o), 0);
    end
    @(negedge clk);
    a_v_i = 0; a_yumi_i = 0; b_v_i = 0; b_yumi_i = 0;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(a_ready_o), 1);
    check("rst_busy", 32'(a_busy_o), 0);
    check("rst_b_ready", 32'(b_ready_o), 1);

    // Basic: settle 2
    sel_b = 1'b0;
    drive(1'b1, 16'hA5C3, 1'b0);
    #1 check("basic_ready0", 32'(cur_ready_o), 1);
    sb_q.push_back(16'hA5C3);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0);
    check("basic_ready_e1", 32'(cur_ready_o), 0);
    check("basic_v_e1", 32'(cur_v_o), 0);
    check("basic_busy_e1", 32'(cur_busy_o), 1);
    @(negedge clk);
    check("basic_ready_e2", 32'(cur_ready_o), 0);
    check("basic_v_e2", 32'(cur_v_o), 0);
    @(negedge clk);
    check("basic_v_e3", 32'(cur_v_o), 1);
    check("basic_data", 32'(cur_data_o), 32'h0000_A5C3);
    @(negedge clk);
    check("basic_hold_v", 32'(cur_v_o), 1);
    drive(1'b0, 16'h0, 1'b1);
    #1 check("basic_passthru", 32'(cur_ready_o), 1);
    consume("basic_pop");
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0);
    check("basic_drained", cur_drained, exp_drained());
    check("basic_idle", 32'(cur_busy_o), 0);

    // Stall: no accept while a word is held
    drive(1'b1, 16'hBEEF, 1'b0);
    #1 check("stall_ready0", 32'(cur_ready_o), 1);
    sb_q.push_back(16'hBEEF);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0);
    w = 0;
    while (!cur_v_o && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("stall_reach_v", 32'(cur_v_o), 1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'h1234, 1'b0);
      #1;
      check("stall_ready", 32'(cur_ready_o), 0);
      check("stall_data", 32'(cur_data_o), 32'h0000_BEEF);
      @(negedge clk);
    end
    check("stall_v", 32'(cur_v_o), 1);
    drive(1'b0, 16'h0, 1'b1);
    consume("stall_pop");
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0);
    check("stall_after_v", 32'(cur_v_o), 0);
    check("stall_drained", cur_drained, exp_drained());

    // Back-to-back, settle 2 -> one word per 3 cycles
    src_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    stream(3);

    // Async reset while settling
    drive(1'b1, 16'h5A5A, 1'b0);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0);
    check("mid_busy", 32'(cur_busy_o), 1);
    #2 a_rst_n = 1'b0;
    #1;
    check("mid_rst_v", 32'(cur_v_o), 0);
    check("mid_rst_busy", 32'(cur_busy_o), 0);
    check("mid_rst_ready", 32'(cur_ready_o), 1);
    check("mid_rst_drained", cur_drained, 0);
    check("mid_rst_data", 32'(cur_data_o), 0);
    drn_a = 0;
    @(negedge clk);
    a_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_after_v", 32'(cur_v_o), 0);

    // Zero settle on B, then wrap of the 2-bit counter
    sel_b = 1'b1;
    src_q = '{16'h0001, 16'hFFFF};
    stream(1);
    check("zero_drained2", cur_drained, 2);
    src_q = '{16'hC0DE, 16'h0F0F, 16'h7E57};
    stream(1);
    check("wrap_drained", cur_drained, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
